// File: rtl/gambit_alloc_pkg.sv
// Shared types and helpers for the queue tail allocator.
// Optional statistics counters are enabled by GAMBIT_ALLOC_STATS_EN.
package gambit_alloc_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } alloc_state_t;

  localparam int CNT_W = 3;
  localparam int RC_W  = 3;

  function automatic int ptr_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int qbits(input int iq_entries);
    return ptr_bits(iq_entries);
  endfunction

  function automatic int rbits(input int rentries);
    return ptr_bits(rentries);
  endfunction

  function automatic int popcount(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++)
      c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/queue_tail_alloc_if.sv
// Handshake bundle between queued-count logic and the tail allocator.
// Statistics ports live on the top module under GAMBIT_ALLOC_STATS_EN.
interface queue_tail_alloc_if
  import gambit_alloc_pkg::*;
#(
  parameter int IQ_ENTRIES = 8,
  parameter int QSLOTS     = 3,
  parameter int RENTRIES   = 16,
  parameter int RSLOTS     = 3
);
  localparam int QBITS = qbits(IQ_ENTRIES);
  localparam int RBITS = rbits(RENTRIES);

  logic                         branchmiss;
  logic [QBITS-1:0]             iq_tail_restore;
  logic [RBITS-1:0]             rob_tail_restore;
  logic [RBITS:0]               rob_cnt_restore;
  logic [CNT_W-1:0]             queuedCnt;
  logic [QSLOTS-1:0]            queuedOnp;
  logic [CNT_W-1:0]             commitCnt;
  logic [QSLOTS-1:0][QBITS-1:0] tails;
  logic [RSLOTS-1:0][RBITS-1:0] rob_tails;
  logic [RBITS:0]               rob_free;
  logic                         rob_nearfull;
  logic                         alloc_stall;
  logic                         alloc_err;

  modport master (
    output branchmiss,
    output iq_tail_restore,
    output rob_tail_restore,
    output rob_cnt_restore,
    output queuedCnt,
    output queuedOnp,
    output commitCnt,
    input  tails,
    input  rob_tails,
    input  rob_free,
    input  rob_nearfull,
    input  alloc_stall,
    input  alloc_err
  );

  modport slave (
    input  branchmiss,
    input  iq_tail_restore,
    input  rob_tail_restore,
    input  rob_cnt_restore,
    input  queuedCnt,
    input  queuedOnp,
    input  commitCnt,
    output tails,
    output rob_tails,
    output rob_free,
    output rob_nearfull,
    output alloc_stall,
    output alloc_err
  );

endinterface

// File: rtl/queue_tail_alloc_ring_ptr_bank.sv
// Base pointer of a power-of-two ring with SLOTS consecutive views.
// Advance and restore wrap by natural truncation.
module ring_ptr_bank
  import gambit_alloc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SLOTS = 3,
  localparam int B = ptr_bits(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CNT_W-1:0]      adv,
  input  logic                  restore,
  input  logic [B-1:0]          restore_ptr,
  output logic [SLOTS-1:0][B-1:0] ptrs
);

  logic [B-1:0] base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      base <= '0;
    else if (restore)
      base <= restore_ptr;
    else
      base <= base + B'(adv);
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    assign ptrs[g] = base + B'(g);
  end

endmodule

// File: rtl/queue_tail_alloc.sv
// IQ/ROB tail allocator with occupancy tracking and branch-miss recovery.
// Define GAMBIT_ALLOC_STATS_EN to add the stat_* counter ports.
module queue_tail_alloc
  import gambit_alloc_pkg::*;
#(
  parameter int IQ_ENTRIES     = 8,
  parameter int QSLOTS         = 3,
  parameter int RENTRIES       = 16,
  parameter int RSLOTS         = 3,
  parameter int WAYS           = 3,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef GAMBIT_ALLOC_STATS_EN
  output logic [31:0] stat_queued,
  output logic [31:0] stat_stall_cycles,
  output logic [31:0] stat_misses,
`endif
  queue_tail_alloc_if.slave bus
);

  localparam int RBITS = rbits(RENTRIES);
  localparam int SW    = RBITS + 3;

  alloc_state_t     state_q;
  logic [RC_W-1:0]  rc_q;
  logic [RBITS:0]   occ_q;
  logic [RBITS:0]   occ_d;
  logic             err_q;

  logic             miss;
  logic             run;
  logic [CNT_W-1:0] add;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    net;
  logic             under;
  logic             over;
  logic [RBITS:0]   free;
  logic             proto_err;
  logic             err_set;

  assign miss = bus.branchmiss;
  assign run  = (state_q == RUN);
  assign add  = (run && !miss) ? bus.queuedCnt : '0;

  ring_ptr_bank #(
    .DEPTH (IQ_ENTRIES),
    .SLOTS (QSLOTS)
  ) u_iq_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .adv         (add),
    .restore     (miss),
    .restore_ptr (bus.iq_tail_restore),
    .ptrs        (bus.tails)
  );

  ring_ptr_bank #(
    .DEPTH (RENTRIES),
    .SLOTS (RSLOTS)
  ) u_rob_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .adv         (add),
    .restore     (miss),
    .restore_ptr (bus.rob_tail_restore),
    .ptrs        (bus.rob_tails)
  );

  // Net occupancy change, computed wide so both bounds are visible.
  assign sum   = SW'(occ_q) + SW'(add);
  assign under = SW'(bus.commitCnt) > sum;
  assign net   = sum - SW'(bus.commitCnt);
  assign over  = !under && (net > SW'(RENTRIES));

  always_comb begin
    occ_d = net[RBITS:0];
    if (miss)
      occ_d = bus.rob_cnt_restore;
    else if (under)
      occ_d = '0;
    else if (over)
      occ_d = (RBITS+1)'(RENTRIES);
  end

  assign free = (RBITS+1)'(RENTRIES) - occ_q;

  assign proto_err =
    (int'(bus.queuedCnt) > WAYS) ||
    (popcount(32'(bus.queuedOnp)) != int'(bus.queuedCnt)) ||
    (int'(bus.queuedCnt) > int'(free));

  assign err_set = !miss && (under || over ||
    (run ? proto_err : (bus.queuedCnt != '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rc_q    <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      occ_q <= occ_d;
      err_q <= err_q | err_set;
      unique case (1'b1)
        miss: begin
          state_q <= RECOVER;
          rc_q    <= RC_W'(RECOVER_CYCLES);
        end
        (!miss && state_q == RECOVER): begin
          rc_q <= rc_q - 1'b1;
          if (rc_q <= RC_W'(1))
            state_q <= RUN;
        end
        default: ;
      endcase
    end
  end

  assign bus.rob_free     = free;
  assign bus.rob_nearfull = int'(free) < WAYS;
  assign bus.alloc_stall  = (state_q == RECOVER);
  assign bus.alloc_err    = err_q;

`ifdef GAMBIT_ALLOC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_queued       <= '0;
      stat_stall_cycles <= '0;
      stat_misses       <= '0;
    end else begin
      stat_queued       <= stat_queued + 32'(add);
      stat_stall_cycles <= stat_stall_cycles + 32'(bus.alloc_stall);
      stat_misses       <= stat_misses + 32'(miss);
    end
  end
`endif

endmodule

// File: tb/tb_queue_tail_alloc.sv
// Table-driven and randomized bench for queue_tail_alloc.
// Randomized traffic is checked against an arithmetic reference model.
module tb_queue_tail_alloc;
  import gambit_alloc_pkg::*;

  localparam int IQ = 8;
  localparam int QS = 3;
  localparam int RE = 16;
  localparam int RS = 3;
  localparam int W  = 3;
  localparam int RC = 2;
  localparam int QB = $clog2(IQ);
  localparam int RB = $clog2(RE);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  queue_tail_alloc_if #(
    .IQ_ENTRIES (IQ), .QSLOTS (QS),
    .RENTRIES (RE), .RSLOTS (RS)
  ) bus ();

  queue_tail_alloc #(
    .IQ_ENTRIES (IQ), .QSLOTS (QS),
    .RENTRIES (RE), .RSLOTS (RS),
    .WAYS (W), .RECOVER_CYCLES (RC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit rst; bit miss;
    int iqr; int robr; int cntr;
    int qc; int onp; int cc;
    int t0; int r0; int free;
    bit nf; bit stall; bit err;
  } vec_t;

  vec_t tbl[21];
  int nvec = 0;
  int nerr = 0;

  // reference model state
  int m_iq, m_rob, m_occ, m_stall;
  bit m_err;
  bit d_miss;
  int d_iqr, d_robr, d_cntr, d_qc, d_cc;
  logic [2:0] d_onp;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_iq = 0; m_rob = 0; m_occ = 0; m_stall = 0; m_err = 0;
  endtask

  task automatic bound(inout int n);
    if (n < 0) begin n = 0; m_err = 1; end
    else if (n > RE) begin n = RE; m_err = 1; end
  endtask

  task automatic model_step();
    int n;
    if (d_miss) begin
      m_iq = d_iqr; m_rob = d_robr; m_occ = d_cntr; m_stall = RC;
    end else if (m_stall == 0) begin
      if (d_qc > W || $countones(d_onp) != d_qc || d_qc > RE - m_occ)
        m_err = 1;
      m_iq  = (m_iq + d_qc) % IQ;
      m_rob = (m_rob + d_qc) % RE;
      n = m_occ + d_qc - d_cc;
      bound(n);
      m_occ = n;
    end else begin
      if (d_qc != 0) m_err = 1;
      n = m_occ - d_cc;
      bound(n);
      m_occ = n;
      m_stall--;
    end
  endtask

  task automatic drive(input bit miss, input int iqr, input int robr,
                       input int cntr, input int qc, input int onp,
                       input int cc);
    d_miss = miss; d_iqr = iqr; d_robr = robr; d_cntr = cntr;
    d_qc = qc; d_onp = 3'(onp); d_cc = cc;
    bus.branchmiss       = miss;
    bus.iq_tail_restore  = QB'(iqr);
    bus.rob_tail_restore = RB'(robr);
    bus.rob_cnt_restore  = (RB+1)'(cntr);
    bus.queuedCnt        = 3'(qc);
    bus.queuedOnp        = 3'(onp);
    bus.commitCnt        = 3'(cc);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic check_model();
    for (int i = 0; i < QS; i++)
      chk($sformatf("model tails[%0d]", i), 32'(bus.tails[i]),
          32'((m_iq + i) % IQ));
    for (int i = 0; i < RS; i++)
      chk($sformatf("model rob_tails[%0d]", i), 32'(bus.rob_tails[i]),
          32'((m_rob + i) % RE));
    chk("model rob_free", 32'(bus.rob_free), 32'(RE - m_occ));
    chk("model nearfull", 32'(bus.rob_nearfull), 32'((RE - m_occ) < W));
    chk("model stall", 32'(bus.alloc_stall), 32'(m_stall > 0));
    chk("model err", 32'(bus.alloc_err), 32'(m_err));
  endtask

  initial begin
    int qc, cc, onp, lim;
    // rst miss iqr robr cntr qc onp cc | t0 r0 free nf stall err
    tbl[0]  = '{1,0,0,0,0, 0,0,0,  0, 0,16,0,0,0};
    tbl[1]  = '{0,0,0,0,0, 3,7,0,  3, 3,13,0,0,0};
    tbl[2]  = '{0,0,0,0,0, 3,7,0,  6, 6,10,0,0,0};
    tbl[3]  = '{0,0,0,0,0, 3,7,0,  1, 9, 7,0,0,0};
    tbl[4]  = '{0,0,0,0,0, 3,7,0,  4,12, 4,0,0,0};
    tbl[5]  = '{0,0,0,0,0, 2,3,0,  6,14, 2,1,0,0};
    tbl[6]  = '{0,0,0,0,0, 1,1,0,  7,15, 1,1,0,0};
    tbl[7]  = '{0,0,0,0,0, 0,0,3,  7,15, 4,0,0,0};
    tbl[8]  = '{0,0,0,0,0, 2,3,0,  1, 1, 2,1,0,0};
    tbl[9]  = '{0,1,5,9,4, 3,7,3,  5, 9,12,0,1,0};
    tbl[10] = '{0,0,0,0,0, 0,0,2,  5, 9,14,0,1,0};
    tbl[11] = '{0,0,0,0,0, 1,1,0,  5, 9,14,0,0,1};
    tbl[12] = '{1,0,0,0,0, 0,0,0,  0, 0,16,0,0,0};
    tbl[13] = '{0,0,0,0,0, 2,1,0,  2, 2,14,0,0,1};
    tbl[14] = '{1,0,0,0,0, 0,0,0,  0, 0,16,0,0,0};
    tbl[15] = '{0,0,0,0,0, 0,0,1,  0, 0,16,0,0,1};
    tbl[16] = '{1,0,0,0,0, 0,0,0,  0, 0,16,0,0,0};
    tbl[17] = '{0,1,0,0,16,0,0,0,  0, 0, 0,1,1,0};
    tbl[18] = '{0,0,0,0,0, 0,0,0,  0, 0, 0,1,1,0};
    tbl[19] = '{0,0,0,0,0, 0,0,0,  0, 0, 0,1,0,0};
    tbl[20] = '{0,0,0,0,0, 1,1,0,  1, 1, 0,1,0,1};

    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].rst)
        do_reset();
      else begin
        drive(tbl[i].miss, tbl[i].iqr, tbl[i].robr, tbl[i].cntr,
              tbl[i].qc, tbl[i].onp, tbl[i].cc);
        step();
      end
      chk($sformatf("v%0d tails0", i), 32'(bus.tails[0]), 32'(tbl[i].t0));
      chk($sformatf("v%0d tails2", i), 32'(bus.tails[2]),
          32'((tbl[i].t0 + 2) % IQ));
      chk($sformatf("v%0d rob0", i), 32'(bus.rob_tails[0]), 32'(tbl[i].r0));
      chk($sformatf("v%0d rob2", i), 32'(bus.rob_tails[2]),
          32'((tbl[i].r0 + 2) % RE));
      chk($sformatf("v%0d free", i), 32'(bus.rob_free), 32'(tbl[i].free));
      chk($sformatf("v%0d nf", i), 32'(bus.rob_nearfull), 32'(tbl[i].nf));
      chk($sformatf("v%0d stall", i), 32'(bus.alloc_stall),
          32'(tbl[i].stall));
      chk($sformatf("v%0d err", i), 32'(bus.alloc_err), 32'(tbl[i].err));
      check_model();
    end

    // async reset in the middle of a recovery window
    do_reset();
    drive(1, 3, 5, 2, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 1, 0);
    step();
    chk("rec stall", 32'(bus.alloc_stall), 32'd1);
    chk("rec err", 32'(bus.alloc_err), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst tails0", 32'(bus.tails[0]), 32'd0);
    chk("arst tails1", 32'(bus.tails[1]), 32'd1);
    chk("arst tails2", 32'(bus.tails[2]), 32'd2);
    chk("arst stall", 32'(bus.alloc_stall), 32'd0);
    chk("arst err", 32'(bus.alloc_err), 32'd0);
    chk("arst free", 32'(bus.rob_free), 32'd16);
    model_reset();
    #1;
    rst_n = 1'b1;

    // randomized traffic against the reference model
    for (int n = 0; n < 800; n++) begin
      if ($urandom % 70 == 0) begin
        do_reset();
      end else begin
        lim = (RE - m_occ) < W ? (RE - m_occ) : W;
        qc = ($urandom % 12 == 0) ? int'($urandom_range(0, 7))
                                  : int'($urandom_range(0, lim));
        onp = (qc >= 3) ? 7 : (qc == 2) ? 6 : (qc == 1) ? 2 : 0;
        if ($urandom % 12 == 0) onp = int'($urandom_range(0, 7));
        lim = m_occ < 3 ? m_occ : 3;
        cc = ($urandom % 15 == 0) ? int'($urandom_range(0, 7))
                                  : int'($urandom_range(0, lim));
        drive($urandom % 18 == 0, int'($urandom_range(0, IQ - 1)),
              int'($urandom_range(0, RE - 1)),
              int'($urandom_range(0, RE)), qc, onp, cc);
        step();
      end
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
